pe_tile_scheduler: RTL and testbench

Sequences the convolution PE over a job of N input tiles. Each tile is a weight/activation pair.
- Accepts tiles over a valid/ready stream and latches them into PE operand registers.
- Holds the PE enable until the PE signals completion, captures the result window and presents it downstream over valid/ready.
- Sits between the tile loader/DMA and the PE; the PE's round mode is configured once per job.

---
 rtl/pe_sched_pkg.sv | 24 ++
 rtl/pe_tile_scheduler_if.sv | 40 ++++
 rtl/pe_tile_scheduler_watchdog.sv | 35 +++
 rtl/pe_tile_scheduler.sv | 157 +++++++++++++++
 tb/tb_pe_tile_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_sched_pkg.sv
// Shared types and bus geometry for the PE tile scheduler.
// The tile/result bus widths are fixed here so the interface, the top and
// any test harness agree on a single geometry.
package pe_sched_pkg;

    localparam int unsigned WORDWIDTH = 32;  // FP32 word width
    localparam int unsigned NUM1      = 14;  // activation words per channel
    localparam int unsigned NUM2      = 5;   // weight words per channel
    localparam int unsigned CHANNEL   = 2;   // channels per tile

    localparam int unsigned W_BUS   = CHANNEL * NUM2 * WORDWIDTH;
    localparam int unsigned A_BUS   = CHANNEL * NUM1 * WORDWIDTH;
    localparam int unsigned OUT_NUM = NUM1 + 1 - NUM2;
    localparam int unsigned R_BUS   = OUT_NUM * WORDWIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StRun,
        StOut,
        StDone
    } state_t;

endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Handshake/bus bundle between the scheduler and its surroundings:
//   tile stream  : tile_valid/tile_ready, tile_w, tile_act (loader -> scheduler)
//   PE side      : pe_en, pe_round_mode, pe_w, pe_act (to PE); pe_oen, pe_result (from PE)
//   result stream: res_valid/res_ready, res_data, res_last (scheduler -> downstream)
// modport master : the scheduler's view
// modport slave  : the loader / PE / downstream view
interface pe_tile_scheduler_if
    import pe_sched_pkg::*;
();

    logic             tile_valid;
    logic             tile_ready;
    logic [W_BUS-1:0] tile_w;
    logic [A_BUS-1:0] tile_act;

    logic             pe_en;
    logic [2:0]       pe_round_mode;
    logic [W_BUS-1:0] pe_w;
    logic [A_BUS-1:0] pe_act;
    logic             pe_oen;
    logic [R_BUS-1:0] pe_result;

    logic             res_valid;
    logic             res_ready;
    logic [R_BUS-1:0] res_data;
    logic             res_last;

    modport master (
        input  tile_valid, tile_w, tile_act, pe_oen, pe_result, res_ready,
        output tile_ready, pe_en, pe_round_mode, pe_w, pe_act,
               res_valid, res_data, res_last
    );

    modport slave (
        output tile_valid, tile_w, tile_act, pe_oen, pe_result, res_ready,
        input  tile_ready, pe_en, pe_round_mode, pe_w, pe_act,
               res_valid, res_data, res_last
    );

endinterface

// File: rtl/pe_tile_scheduler_watchdog.sv
// Cycle watchdog for the PE RUN phase.
// Ports:
//   clk, rstn : clock, async active-low reset
//   clear     : restart the count (tile accepted)
//   run       : PE is running; counts one per cycle
//   expired   : high on the TIMEOUT-th consecutive run cycle
module pe_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // First run cycle sees count 0, so expiry lands on run cycle TIMEOUT.
    assign expired = run && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pe_tile_scheduler.sv
// Sequences the convolution PE over a job of num_tiles tiles: fetch a tile,
// hold pe_en until the PE reports completion, then hand the result window
// downstream. A watchdog aborts the job if the PE never answers.
// Ports:
//   clk, rstn        : clock, async active-low reset
//   start, num_tiles, round_mode_in : job control, sampled while idle
//   busy, done, err_timeout, tiles_done : job status
//   bus (master)     : tile stream, PE operands/result, result stream
module pe_tile_scheduler
    import pe_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_tiles,
    input  logic [2:0]         round_mode_in,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   tiles_done,
    pe_tile_scheduler_if.master bus
);

    state_t state_q, state_d;

    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] tiles_done_q;
    logic [2:0]       round_mode_q;
    logic [W_BUS-1:0] pe_w_q;
    logic [A_BUS-1:0] pe_act_q;
    logic [R_BUS-1:0] res_data_q;
    logic             err_q;

    logic start_ok;
    logic tile_acc;
    logic pe_hit;
    logic res_acc;
    logic is_last;
    logic wd_expired;

    assign start_ok = (state_q == StIdle) && start;
    assign tile_acc = (state_q == StFetch) && bus.tile_valid;
    assign pe_hit   = (state_q == StRun) && bus.pe_oen;
    assign res_acc  = (state_q == StOut) && bus.res_ready;
    assign is_last  = (tiles_done_q == (num_q - CNT_W'(1)));

    pe_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tile_acc),
        .run     (state_q == StRun),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_tiles != '0) ? StFetch : StDone;
                end
            end
            StFetch: begin
                if (bus.tile_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A completion on the expiry cycle still wins over the abort.
                if (bus.pe_oen) begin
                    state_d = StOut;
                end else if (wd_expired) begin
                    state_d = StDone;
                end
            end
            StOut: begin
                if (bus.res_ready) begin
                    state_d = is_last ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; pe_en follows the async reset of state_q.
    always_comb begin
        busy           = (state_q != StIdle);
        done           = (state_q == StDone);
        bus.tile_ready = (state_q == StFetch);
        bus.pe_en      = (state_q == StRun);
        bus.res_valid  = (state_q == StOut);
        bus.res_last   = (state_q == StOut) && is_last;
    end

    // Datapath and job bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q        <= '0;
            tiles_done_q <= '0;
            round_mode_q <= '0;
            pe_w_q       <= '0;
            pe_act_q     <= '0;
            res_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            if (start_ok) begin
                err_q        <= 1'b0;
                tiles_done_q <= '0;
                if (num_tiles != '0) begin
                    num_q        <= num_tiles;
                    round_mode_q <= round_mode_in;
                end
            end
            if (tile_acc) begin
                pe_w_q   <= bus.tile_w;
                pe_act_q <= bus.tile_act;
            end
            if (pe_hit) begin
                res_data_q <= bus.pe_result;
            end
            if ((state_q == StRun) && !bus.pe_oen && wd_expired) begin
                err_q <= 1'b1;
            end
            if (res_acc) begin
                tiles_done_q <= tiles_done_q + CNT_W'(1);
            end
        end
    end

    assign err_timeout       = err_q;
    assign tiles_done        = tiles_done_q;
    assign bus.pe_round_mode = round_mode_q;
    assign bus.pe_w          = pe_w_q;
    assign bus.pe_act        = pe_act_q;
    assign bus.res_data      = res_data_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Directed bench for pe_tile_scheduler with a small PE model that answers
// PE_LAT cycles after pe_en rises.
module tb_pe_tile_scheduler;
    import pe_sched_pkg::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int          PE_LAT  = 6;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [CNT_W-1:0] num_tiles;
    logic [2:0]       round_mode_in;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [CNT_W-1:0] tiles_done;

    pe_tile_scheduler_if bus ();

    pe_tile_scheduler #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .num_tiles     (num_tiles),
        .round_mode_in (round_mode_in),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .tiles_done    (tiles_done),
        .bus           (bus)
    );

    int errors = 0;
    int checks = 0;

    logic pe_auto;
    logic force_oen;
    int   pe_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PE model: acts 2 time units after the edge, clear of the main sequence.
    initial begin
        pe_cnt     = 0;
        bus.pe_oen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.pe_en) pe_cnt = pe_cnt + 1;
            else pe_cnt = 0;
            bus.pe_oen = (pe_auto && bus.pe_en && (pe_cnt == PE_LAT)) || force_oen;
        end
    end

    task automatic check(input string tag, input logic [A_BUS-1:0] obs,
                         input logic [A_BUS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.res_valid;
            1:       return done;
            default: return bus.pe_en;
        endcase
    endfunction

    task automatic wait_for(input int which, input int maxc, input string tag);
        int n = 0;
        while (!sel(which) && n < maxc) begin
            step();
            n++;
        end
        check(tag, A_BUS'(sel(which)), A_BUS'(1'b1));
    endtask

    logic [W_BUS-1:0] w1, w2;
    logic [A_BUS-1:0] a1;
    logic [R_BUS-1:0] r1, r_k, junk;
    int               run_cycles;
    logic             saw_res;
    logic             saw_en;

    initial begin
        w1   = {10{32'h1111_0001}};
        w2   = {10{32'h2222_0002}};
        a1   = {28{32'hA5A5_0003}};
        r1   = {10{32'h3F80_0000}};
        junk = {10{32'hDEAD_BEEF}};

        rstn          = 1'b0;
        start         = 1'b0;
        num_tiles     = '0;
        round_mode_in = 3'b000;
        bus.tile_valid = 1'b0;
        bus.tile_w    = '0;
        bus.tile_act  = '0;
        bus.pe_result = '0;
        bus.res_ready = 1'b0;
        pe_auto       = 1'b0;
        force_oen     = 1'b0;

        // Reset state
        step();
        step();
        check("rst_busy", A_BUS'(busy), '0);
        check("rst_done", A_BUS'(done), '0);
        check("rst_err", A_BUS'(err_timeout), '0);
        check("rst_tiles_done", A_BUS'(tiles_done), '0);
        check("rst_tile_ready", A_BUS'(bus.tile_ready), '0);
        check("rst_pe_en", A_BUS'(bus.pe_en), '0);
        check("rst_res_valid", A_BUS'(bus.res_valid), '0);
        check("rst_pe_w", A_BUS'(bus.pe_w), '0);
        check("rst_res_data", A_BUS'(bus.res_data), '0);
        check("rst_round", A_BUS'(bus.pe_round_mode), '0);
        rstn = 1'b1;
        step();

        // Single tile
        pe_auto        = 1'b1;
        bus.tile_valid = 1'b1;
        bus.tile_w     = w1;
        bus.tile_act   = a1;
        bus.pe_result  = r1;
        start          = 1'b1;
        num_tiles      = 16'd1;
        step();
        start = 1'b0;
        check("t1_tile_ready", A_BUS'(bus.tile_ready), A_BUS'(1'b1));
        check("t1_busy", A_BUS'(busy), A_BUS'(1'b1));
        step();
        bus.tile_valid = 1'b0;
        check("t1_pe_en", A_BUS'(bus.pe_en), A_BUS'(1'b1));
        check("t1_pe_w", A_BUS'(bus.pe_w), A_BUS'(w1));
        check("t1_pe_act", bus.pe_act, a1);
        wait_for(0, 20, "t1_res_valid_wait");
        check("t1_res_data", A_BUS'(bus.res_data), A_BUS'(r1));
        check("t1_res_last", A_BUS'(bus.res_last), A_BUS'(1'b1));
        check("t1_pe_en_low", A_BUS'(bus.pe_en), '0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t1_done", A_BUS'(done), A_BUS'(1'b1));
        check("t1_tiles_done", A_BUS'(tiles_done), A_BUS'(1));
        check("t1_res_valid_off", A_BUS'(bus.res_valid), '0);
        step();
        check("t1_done_one_cycle", A_BUS'(done), '0);
        check("t1_idle", A_BUS'(busy), '0);

        // Three tiles with backpressure
        round_mode_in  = 3'b101;
        bus.tile_valid = 1'b1;
        bus.tile_w     = w2;
        start          = 1'b1;
        num_tiles      = 16'd3;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_k           = {10{32'h4000_0000 + 32'(k)}};
            bus.pe_result = r_k;
            wait_for(0, 30, $sformatf("t2_res_valid_wait%0d", k));
            check($sformatf("t2_res_data%0d", k), A_BUS'(bus.res_data), A_BUS'(r_k));
            check($sformatf("t2_res_last%0d", k), A_BUS'(bus.res_last),
                  A_BUS'(k == 2));
            bus.pe_result = junk;
            for (int s = 0; s < 4; s++) step();
            check($sformatf("t2_stall_valid%0d", k), A_BUS'(bus.res_valid), A_BUS'(1'b1));
            check($sformatf("t2_stall_data%0d", k), A_BUS'(bus.res_data), A_BUS'(r_k));
            check($sformatf("t2_stall_ready%0d", k), A_BUS'(bus.tile_ready), '0);
            bus.res_ready = 1'b1;
            step();
            bus.res_ready = 1'b0;
            check($sformatf("t2_tiles_done%0d", k), A_BUS'(tiles_done), A_BUS'(k + 1));
        end
        check("t2_done", A_BUS'(done), A_BUS'(1'b1));
        check("t2_round", A_BUS'(bus.pe_round_mode), A_BUS'(3'b101));
        check("t2_pe_w_hold", A_BUS'(bus.pe_w), A_BUS'(w2));
        step();

        // Zero-length job
        bus.tile_valid = 1'b1;
        start          = 1'b1;
        num_tiles      = 16'd0;
        step();
        start = 1'b0;
        check("t3_done", A_BUS'(done), A_BUS'(1'b1));
        check("t3_busy", A_BUS'(busy), A_BUS'(1'b1));
        check("t3_tile_ready", A_BUS'(bus.tile_ready), '0);
        step();
        check("t3_done_off", A_BUS'(done), '0);
        check("t3_busy_off", A_BUS'(busy), '0);
        check("t3_round_hold", A_BUS'(bus.pe_round_mode), A_BUS'(3'b101));

        // Timeout: PE never answers
        pe_auto   = 1'b0;
        start     = 1'b1;
        num_tiles = 16'd2;
        step();
        start = 1'b0;
        step();
        bus.tile_valid = 1'b0;
        check("t4_pe_en", A_BUS'(bus.pe_en), A_BUS'(1'b1));
        run_cycles = 1;
        saw_res    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.res_valid) saw_res = 1'b1;
            if (!bus.pe_en) break;
            run_cycles++;
        end
        check("t4_run_cycles", A_BUS'(run_cycles), A_BUS'(TIMEOUT));
        check("t4_done", A_BUS'(done), A_BUS'(1'b1));
        check("t4_err", A_BUS'(err_timeout), A_BUS'(1'b1));
        check("t4_no_res", A_BUS'(saw_res), '0);
        check("t4_tiles_done", A_BUS'(tiles_done), '0);
        step();
        check("t4_err_sticky", A_BUS'(err_timeout), A_BUS'(1'b1));
        pe_auto        = 1'b1;
        bus.tile_valid = 1'b1;
        bus.pe_result  = r1;
        start          = 1'b1;
        num_tiles      = 16'd1;
        step();
        start = 1'b0;
        check("t4_err_cleared", A_BUS'(err_timeout), '0);
        wait_for(0, 20, "t4_res_valid_wait");
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t4_rerun_done", A_BUS'(done), A_BUS'(1'b1));
        step();

        // Reset while the PE is running
        pe_auto   = 1'b0;
        start     = 1'b1;
        num_tiles = 16'd1;
        step();
        start = 1'b0;
        step();
        check("t5_pe_en", A_BUS'(bus.pe_en), A_BUS'(1'b1));
        #2;
        rstn = 1'b0;
        #1;
        check("t5_async_pe_en", A_BUS'(bus.pe_en), '0);
        check("t5_async_busy", A_BUS'(busy), '0);
        check("t5_async_pe_w", A_BUS'(bus.pe_w), '0);
        step();
        rstn = 1'b1;
        step();
        pe_auto   = 1'b1;
        start     = 1'b1;
        num_tiles = 16'd1;
        step();
        start = 1'b0;
        wait_for(0, 20, "t5_res_valid_wait");
        check("t5_res_data", A_BUS'(bus.res_data), A_BUS'(r1));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t5_done", A_BUS'(done), A_BUS'(1'b1));
        check("t5_tiles_done", A_BUS'(tiles_done), A_BUS'(1));
        step();

        // Loader stall, stray pe_oen in FETCH, start during RUN
        bus.tile_valid = 1'b0;
        start          = 1'b1;
        num_tiles      = 16'd1;
        step();
        start  = 1'b0;
        saw_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            force_oen = (i == 3);
            step();
            if (bus.pe_en || bus.res_valid) saw_en = 1'b1;
        end
        force_oen = 1'b0;
        check("t6_stall_pe_en", A_BUS'(saw_en), '0);
        check("t6_stall_ready", A_BUS'(bus.tile_ready), A_BUS'(1'b1));
        bus.tile_valid = 1'b1;
        bus.tile_w     = w1;
        step();
        bus.tile_valid = 1'b0;
        start     = 1'b1;
        num_tiles = 16'd5;
        step();
        start = 1'b0;
        wait_for(0, 20, "t6_res_valid_wait");
        check("t6_res_last", A_BUS'(bus.res_last), A_BUS'(1'b1));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t6_done", A_BUS'(done), A_BUS'(1'b1));
        check("t6_tiles_done", A_BUS'(tiles_done), A_BUS'(1));
        step();
        check("t6_idle", A_BUS'(busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
